best_match_comparator: RTL and testbench



---
 rtl/best_match_comparator.sv | 135 +++++++++++++
 tb/tb_best_match_comparator.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/best_match_comparator.sv
`timescale 1ns/1ps
// best_match_comparator: tracks the minimum SAD over a NUM_POS x NUM_POS raster scan and reports its displacement.
// Optional early exit on an exact (zero SAD) match is enabled by defining BEST_MATCH_ZERO_EXIT_EN.
module best_match_comparator #(
   parameter int DIST_W  = 16,
   parameter int VEC_W   = 4,
   parameter int NUM_POS = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              dist_valid,
   input  logic [DIST_W-1:0] distortion,
   output logic [VEC_W-1:0]  motionx,
   output logic [VEC_W-1:0]  motiony,
   output logic [DIST_W-1:0] best_dist,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_POS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   // Window position to signed displacement centred on the search origin.
   function automatic logic signed [VEC_W-1:0] to_vec(input logic [CNT_W-1:0] c);
      return $signed(VEC_W'(c) - VEC_W'(NUM_POS / 2));
   endfunction

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          col_q, col_d, row_q, row_d;
   logic [CNT_W-1:0]          best_col_q, best_col_d, best_row_q, best_row_d;
   logic [DIST_W-1:0]         min_q, min_d;
   logic signed [VEC_W-1:0]   motionx_q, motionx_d, motiony_q, motiony_d;
   logic [DIST_W-1:0]         best_dist_q, best_dist_d;

   logic consume, is_better, last_cand, zero_hit, finish;

   always_comb begin
      consume   = (state_q == SCAN) && dist_valid && !start;
      is_better = distortion < min_q;
      last_cand = (col_q == LAST) && (row_q == LAST);
`ifdef BEST_MATCH_ZERO_EXIT_EN
      zero_hit  = (distortion == '0);
`else
      zero_hit  = 1'b0;
`endif
      finish    = consume && (last_cand || zero_hit);
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; start restarts the scan from any state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (start) state_d = SCAN;
                  else if (finish) state_d = DONE;
         DONE:    state_d = start ? SCAN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      busy = (state_q == SCAN);
      done = (state_q == DONE);
   end

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      min_d       = min_q;
      best_col_d  = best_col_q;
      best_row_d  = best_row_q;
      motionx_d   = motionx_q;
      motiony_d   = motiony_q;
      best_dist_d = best_dist_q;
      if (start) begin
         col_d      = '0;
         row_d      = '0;
         min_d      = '1;
         best_col_d = '0;
         best_row_d = '0;
      end else if (consume) begin
         if (is_better) begin
            min_d      = distortion;
            best_col_d = col_q;
            best_row_d = row_q;
         end
         col_d = (col_q == LAST) ? '0 : col_q + CNT_W'(1);
         if (col_q == LAST) row_d = (row_q == LAST) ? '0 : row_q + CNT_W'(1);
         // Fold the final compare straight into the outputs so they are valid alongside done.
         if (finish) begin
            motionx_d   = to_vec(is_better ? col_q : best_col_q);
            motiony_d   = to_vec(is_better ? row_q : best_row_q);
            best_dist_d = is_better ? distortion : min_q;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         motionx_q   <= '0;
         motiony_q   <= '0;
         best_dist_q <= '1;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         motionx_q   <= motionx_d;
         motiony_q   <= motiony_d;
         best_dist_q <= best_dist_d;
      end
   end

   // Running minimum is always preloaded by start, so it needs no reset.
   always_ff @(posedge clock) begin
      min_q      <= min_d;
      best_col_q <= best_col_d;
      best_row_q <= best_row_d;
   end

   assign motionx   = motionx_q;
   assign motiony   = motiony_q;
   assign best_dist = best_dist_q;

endmodule

// File: tb/tb_best_match_comparator.sv
`timescale 1ns/1ps
// Directed vector bench for best_match_comparator: full scans from a table plus restart, reset and zero-exit sequences.
module tb_best_match_comparator;

   logic        clock = 1'b0;
   logic        reset, start, dist_valid;
   logic [15:0] distortion;
   logic [3:0]  motionx, motiony;
   logic [15:0] best_dist;
   logic        busy, done;

   int total = 0;
   int bad = 0;
   int done_seen = 0;

   best_match_comparator #(.DIST_W(16), .VEC_W(4), .NUM_POS(16)) dut (
      .clock(clock), .reset(reset), .start(start), .dist_valid(dist_valid),
      .distortion(distortion), .motionx(motionx), .motiony(motiony),
      .best_dist(best_dist), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          min_idx;
      int          tie_idx;
      logic [15:0] min_val;
      logic [15:0] base;
      int          gap;
      logic [3:0]  mx;
      logic [3:0]  my;
      logic [15:0] bd;
   } vec_t;

`ifdef BEST_MATCH_ZERO_EXIT_EN
   localparam int N_VEC = 5;
`else
   localparam int N_VEC = 6;
`endif
   vec_t vecs[N_VEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
      if (done) done_seen++;
   endtask

   task automatic start_pulse;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input int first, input int n, input int min_idx, input int tie_idx,
                       input logic [15:0] min_val, input logic [15:0] base, input int gap_max);
      for (int i = first; i < first + n; i++) begin
         if (gap_max > 0) begin
            dist_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) tick();
         end
         dist_valid = 1'b1;
         distortion = (i == min_idx || i == tie_idx) ? min_val : base;
         tick();
      end
      dist_valid = 1'b0;
   endtask

   initial begin
      // idx = row*16 + col; expected vector = (col-8, row-8) in 4-bit two's complement
      vecs[0] = '{90,  -1, 16'd12,    16'd1000,  0, 4'h2, 4'hD, 16'd12};
      vecs[1] = '{0,   -1, 16'd500,   16'd500,   0, 4'h8, 4'h8, 16'd500};
      vecs[2] = '{255, -1, 16'd7,     16'd1000,  3, 4'h7, 4'h7, 16'd7};
      vecs[3] = '{-1,  -1, 16'hFFFF,  16'hFFFF,  0, 4'h8, 4'h8, 16'hFFFF};
      vecs[4] = '{37,  200, 16'd9,    16'd1000,  1, 4'hD, 4'hA, 16'd9};
`ifndef BEST_MATCH_ZERO_EXIT_EN
      vecs[5] = '{20,  200, 16'd0,    16'd1000,  0, 4'hC, 4'h9, 16'd0};
`endif

      reset = 1'b1; start = 1'b0; dist_valid = 1'b0; distortion = '0;
      #12;
      chk("rst_motionx", motionx, 4'h0);
      chk("rst_motiony", motiony, 4'h0);
      chk("rst_best_dist", best_dist, 16'hFFFF);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      tick();

      for (int v = 0; v < N_VEC; v++) begin
         done_seen = 0;
         start_pulse();
         chk($sformatf("v%0d_busy", v), busy, 1'b1);
         feed(0, 256, vecs[v].min_idx, vecs[v].tie_idx, vecs[v].min_val, vecs[v].base, vecs[v].gap);
         chk($sformatf("v%0d_done", v), done, 1'b1);
         chk($sformatf("v%0d_done_count", v), done_seen, 1);
         chk($sformatf("v%0d_motionx", v), motionx, vecs[v].mx);
         chk($sformatf("v%0d_motiony", v), motiony, vecs[v].my);
         chk($sformatf("v%0d_best_dist", v), best_dist, vecs[v].bd);
         tick();
         chk($sformatf("v%0d_done_fall", v), done, 1'b0);
         chk($sformatf("v%0d_idle_busy", v), busy, 1'b0);
      end

      // Aborted search: 100 valids with a low minimum, then restart with a colliding sample
      done_seen = 0;
      start_pulse();
      feed(0, 100, 10, -1, 16'd2, 16'd1000, 0);
      chk("abort_no_done", done_seen, 0);
      chk("abort_hold_bd", best_dist, vecs[N_VEC-1].bd);
      start = 1'b1; dist_valid = 1'b1; distortion = 16'd1;
      tick();
      start = 1'b0; dist_valid = 1'b0;
      chk("restart_busy", busy, 1'b1);
      chk("restart_hold_mx", motionx, vecs[N_VEC-1].mx);
      feed(0, 256, 136, -1, 16'd3, 16'd1000, 0);
      chk("restart_done", done, 1'b1);
      chk("restart_done_count", done_seen, 1);
      chk("restart_motionx", motionx, 4'h0);
      chk("restart_motiony", motiony, 4'h0);
      chk("restart_best_dist", best_dist, 16'd3);
      tick();

      // Asynchronous reset part-way through a scan
      start_pulse();
      feed(0, 50, 5, -1, 16'd4, 16'd800, 0);
      #2 reset = 1'b1;
      #1;
      chk("midrst_motionx", motionx, 4'h0);
      chk("midrst_motiony", motiony, 4'h0);
      chk("midrst_best_dist", best_dist, 16'hFFFF);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      done_seen = 0;
      feed(0, 256, 5, -1, 16'd1, 16'd800, 0);
      chk("nostart_no_done", done_seen, 0);
      chk("nostart_busy", busy, 1'b0);
      chk("nostart_best_dist", best_dist, 16'hFFFF);

`ifdef BEST_MATCH_ZERO_EXIT_EN
      // Exact match at candidate 20 ends the search early
      done_seen = 0;
      start_pulse();
      feed(0, 21, 20, -1, 16'd0, 16'd1000, 0);
      chk("zx_done", done, 1'b1);
      chk("zx_motionx", motionx, 4'hC);
      chk("zx_motiony", motiony, 4'h9);
      chk("zx_best_dist", best_dist, 16'd0);
      feed(21, 20, 30, -1, 16'd5, 16'd700, 0);
      chk("zx_done_count", done_seen, 1);
      chk("zx_idle_busy", busy, 1'b0);
      chk("zx_hold_bd", best_dist, 16'd0);
      chk("zx_hold_mx", motionx, 4'hC);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
